// File: rtl/serial_pkg.sv
// Shared definitions for the serial transmitter and receiver: the frame FSM
// state encoding and the fixed line levels of a UART-style frame.
package serial_pkg;

   localparam int   DATA_BITS   = 8;
   localparam logic START_LEVEL = 1'b0;
   localparam logic STOP_LEVEL  = 1'b1;
   localparam logic IDLE_LEVEL  = 1'b1;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } state_t;

endpackage

// File: rtl/bit_timer.sv
// Bit-period timer shared by the serial transmitter and receiver.
// A down-counter reloads to CLKS_PER_BIT-1 on clear and on every terminal
// count, so one bit period is exactly CLKS_PER_BIT enabled cycles.
// bit_done marks the last cycle of a bit, bit_almost the cycle before it.
module bit_timer #(
   parameter int CLKS_PER_BIT = 10
) (
   input  logic clock,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic bit_done,
   output logic bit_almost
);

   localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] TOP = CW'(CLKS_PER_BIT - 1);

   logic [CW-1:0] count;

   // reload on clear or terminal count, otherwise count down while enabled
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         count <= '0;
      end else if (clear) begin
         count <= TOP;
      end else if (enable) begin
         if (count == '0) begin
            count <= TOP;
         end else begin
            count <= count - 1'b1;
         end
      end
   end

   // terminal-count compares, qualified so an idle timer never reports a bit
   always_comb begin
      bit_done   = enable && (count == '0);
      bit_almost = enable && (count == CW'(1));
   end

endmodule

// File: rtl/serial_transmit.sv
// UART-style transmitter: start bit, DATA_BITS data bits LSB first, optional
// even-parity bit, stop bit. Every bit lasts CLKS_PER_BIT clocks.
// Build option: define SERIAL_TRANSMIT_PARITY_EN to insert the parity bit
// between the last data bit and the stop bit (11-bit frame).
//
// state  | meaning
// IDLE   | line high, waiting for txstart
// START  | driving the start bit (low)
// DATA   | driving data bits, LSB first, shifting on each bit boundary
// PARITY | driving even parity of the latched byte (parity build only)
// STOP   | driving the stop bit (high); txfinish in its final cycle
module serial_transmit #(
   parameter int CLKS_PER_BIT = 10,
   parameter int DATA_BITS    = 8
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic [DATA_BITS-1:0] txdata,
   input  logic                 txstart,
   output logic                 tx,
   output logic                 txbusy,
   output logic                 txfinish
);

   import serial_pkg::*;

   localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

   state_t               state;
   logic [DATA_BITS-1:0] shift;
   logic [IDX_W-1:0]     bit_idx;
   logic                 timer_clear;
   logic                 timer_enable;
   logic                 bit_done;
   logic                 bit_almost;
`ifdef SERIAL_TRANSMIT_PARITY_EN
   logic                 parity_bit;
`endif

   // timer restarts on acceptance and runs for the whole frame
   always_comb begin
      timer_clear  = (state == IDLE) && txstart;
      timer_enable = (state != IDLE);
   end

   bit_timer #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_bit_timer (
      .clock      (clock),
      .reset      (reset),
      .clear      (timer_clear),
      .enable     (timer_enable),
      .bit_done   (bit_done),
      .bit_almost (bit_almost)
   );

   // frame sequencer; tx, txbusy and txfinish all come straight from flops
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state    <= IDLE;
         tx       <= IDLE_LEVEL;
         txbusy   <= 1'b0;
         txfinish <= 1'b0;
         shift    <= '0;
         bit_idx  <= '0;
`ifdef SERIAL_TRANSMIT_PARITY_EN
         parity_bit <= 1'b0;
`endif
      end else begin
         txfinish <= 1'b0;
         case (state)
            IDLE: begin
               tx     <= IDLE_LEVEL;
               txbusy <= 1'b0;
               if (txstart) begin
                  shift   <= txdata;
                  bit_idx <= '0;
`ifdef SERIAL_TRANSMIT_PARITY_EN
                  parity_bit <= ^txdata;
`endif
                  tx      <= START_LEVEL;
                  txbusy  <= 1'b1;
                  state   <= START;
               end
            end
            START: begin
               if (bit_done) begin
                  tx      <= shift[0];
                  shift   <= shift >> 1;
                  bit_idx <= '0;
                  state   <= DATA;
               end
            end
            DATA: begin
               if (bit_done) begin
                  if (bit_idx == LAST_IDX) begin
`ifdef SERIAL_TRANSMIT_PARITY_EN
                     tx    <= parity_bit;
                     state <= PARITY;
`else
                     tx    <= STOP_LEVEL;
                     state <= STOP;
`endif
                  end else begin
                     tx      <= shift[0];
                     shift   <= shift >> 1;
                     bit_idx <= bit_idx + 1'b1;
                  end
               end
            end
            PARITY: begin
`ifdef SERIAL_TRANSMIT_PARITY_EN
               if (bit_done) begin
                  tx    <= STOP_LEVEL;
                  state <= STOP;
               end
`else
               // unreachable without the parity option; fall back to idle
               tx     <= IDLE_LEVEL;
               txbusy <= 1'b0;
               state  <= IDLE;
`endif
            end
            STOP: begin
               // raise txfinish one cycle early so it lands on the final cycle
               if (bit_almost) begin
                  txfinish <= 1'b1;
               end
               if (bit_done) begin
                  tx     <= IDLE_LEVEL;
                  txbusy <= 1'b0;
                  state  <= IDLE;
               end
            end
            default: begin
               tx     <= IDLE_LEVEL;
               txbusy <= 1'b0;
               state  <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_transmit.sv
// Self-checking bench for serial_transmit. Stimulus is a per-cycle schedule
// of txstart/txdata; the expected line is rebuilt from frame rules
// (slot = cycles-into-frame / CLKS_PER_BIT) and compared cycle by cycle.
module tb_serial_transmit;

   localparam int CPB = 10;
`ifdef SERIAL_TRANSMIT_PARITY_EN
   localparam int FRAME_BITS = 11;
`else
   localparam int FRAME_BITS = 10;
`endif
   localparam int FL   = FRAME_BITS * CPB;
   localparam int MAXC = 600;

   logic       clock   = 1'b0;
   logic       reset   = 1'b1;
   logic [7:0] txdata  = 8'h00;
   logic       txstart = 1'b0;
   logic       tx;
   logic       txbusy;
   logic       txfinish;

   int n_assert = 0;
   int n_fail   = 0;

   logic       sch_start [MAXC];
   logic [7:0] sch_data  [MAXC];
   logic       cap_tx    [MAXC];
   logic       cap_busy  [MAXC];
   logic       cap_fin   [MAXC];
   logic       exp_tx    [MAXC];
   logic       exp_busy  [MAXC];
   logic       exp_fin   [MAXC];

   serial_transmit #(
      .CLKS_PER_BIT (CPB),
      .DATA_BITS    (8)
   ) dut (
      .clock    (clock),
      .reset    (reset),
      .txdata   (txdata),
      .txstart  (txstart),
      .tx       (tx),
      .txbusy   (txbusy),
      .txfinish (txfinish)
   );

   always #5 clock = ~clock;

   initial begin
      #2000000;
      $display("FAIL watchdog: time limit reached, summary not printed");
      $fatal(1, "watchdog");
   end

   // line level of frame slot 'slot' for byte d
   function automatic logic frame_level(input logic [7:0] d, input int slot);
      if (slot == 0) return 1'b0;
      if (slot <= 8) return d[slot-1];
`ifdef SERIAL_TRANSMIT_PARITY_EN
      if (slot == 9) return ^d;
`endif
      return 1'b1;
   endfunction

   task automatic clear_sched();
      for (int i = 0; i < MAXC; i++) begin
         sch_start[i] = 1'b0;
         sch_data[i]  = 8'h00;
      end
   endtask

   // reference: a request seen while idle starts a frame on the next cycle
   task automatic build_model(input int n);
      bit         active = 1'b0;
      int         a = 0;
      logic [7:0] d = 8'h00;
      int         k;
      for (int i = 0; i < n; i++) begin
         if (active && (i - a - 1) >= FL) active = 1'b0;
         if (active) begin
            k = i - a - 1;
            exp_tx[i]   = frame_level(d, k / CPB);
            exp_busy[i] = 1'b1;
            exp_fin[i]  = (k == FL - 1);
         end else begin
            exp_tx[i]   = 1'b1;
            exp_busy[i] = 1'b0;
            exp_fin[i]  = 1'b0;
            if (sch_start[i]) begin
               active = 1'b1;
               a      = i;
               d      = sch_data[i];
            end
         end
      end
   endtask

   // sample outputs at each falling edge, then apply that cycle's inputs
   task automatic run_sched(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clock);
         cap_tx[i]   = tx;
         cap_busy[i] = txbusy;
         cap_fin[i]  = txfinish;
         txstart     = sch_start[i];
         txdata      = sch_data[i];
      end
      txstart = 1'b0;
   endtask

   task automatic test_reset();
      txstart = 1'b1;
      txdata  = 8'($urandom);
      #2 reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clock);
         n_assert++;
         if ({tx, txbusy, txfinish} !== 3'b100) begin
            n_fail++;
            $display("FAIL reset_hold cycle %0d: tx/busy/fin got %b%b%b expected 100", i, tx, txbusy, txfinish);
         end
      end
      reset = 1'b1;
      @(posedge clock);
      #1 txstart = 1'b0;
      @(negedge clock);
      n_assert++;
      if ({tx, txbusy} !== 2'b01) begin
         n_fail++;
         $display("FAIL reset_release_start: tx/busy got %b%b expected 01", tx, txbusy);
      end
      repeat (FL + 2) @(negedge clock);
      n_assert++;
      if ({tx, txbusy, txfinish} !== 3'b100) begin
         n_fail++;
         $display("FAIL reset_release_idle: tx/busy/fin got %b%b%b expected 100", tx, txbusy, txfinish);
      end
   endtask

   task automatic test_single_byte();
      int n = FL + 10;
      int busy_cnt = 0;
      int fin_at = -1;
      clear_sched();
      sch_start[0] = 1'b1;
      sch_data[0]  = 8'hA5;
      build_model(n);
      run_sched(n);
      for (int i = 0; i < n; i++) begin
         n_assert++;
         if ({cap_tx[i], cap_busy[i], cap_fin[i]} !== {exp_tx[i], exp_busy[i], exp_fin[i]}) begin
            n_fail++;
            $display("FAIL single cycle %0d: tx/busy/fin got %b%b%b expected %b%b%b", i,
                     cap_tx[i], cap_busy[i], cap_fin[i], exp_tx[i], exp_busy[i], exp_fin[i]);
         end
         if (cap_busy[i] === 1'b1) busy_cnt++;
         if (cap_fin[i] === 1'b1) fin_at = i;
      end
      n_assert++;
      if (busy_cnt != FL) begin
         n_fail++;
         $display("FAIL single_busy_len: got %0d expected %0d", busy_cnt, FL);
      end
      n_assert++;
      if (fin_at != FL) begin
         n_fail++;
         $display("FAIL single_finish_cycle: got %0d expected %0d", fin_at, FL);
      end
   endtask

   task automatic test_ignored_request();
      int n = FL + 30;
      int fin_cnt = 0;
      clear_sched();
      sch_start[0]  = 1'b1;
      sch_data[0]   = 8'h3C;
      sch_start[40] = 1'b1;
      sch_data[40]  = 8'hFF;
      for (int i = 41; i < 60; i++) sch_data[i] = 8'($urandom);
      build_model(n);
      run_sched(n);
      for (int i = 0; i < n; i++) begin
         n_assert++;
         if ({cap_tx[i], cap_busy[i], cap_fin[i]} !== {exp_tx[i], exp_busy[i], exp_fin[i]}) begin
            n_fail++;
            $display("FAIL ignored cycle %0d: tx/busy/fin got %b%b%b expected %b%b%b", i,
                     cap_tx[i], cap_busy[i], cap_fin[i], exp_tx[i], exp_busy[i], exp_fin[i]);
         end
         if (cap_fin[i] === 1'b1) fin_cnt++;
      end
      n_assert++;
      if (fin_cnt != 1) begin
         n_fail++;
         $display("FAIL ignored_frame_count: got %0d expected 1", fin_cnt);
      end
   endtask

   task automatic test_back_to_back();
      int n = 2 * FL + 10;
      clear_sched();
      for (int i = 0; i <= FL + 1; i++) begin
         sch_start[i] = 1'b1;
         sch_data[i]  = (i < FL / 2) ? 8'h00 : 8'hFF;
      end
      build_model(n);
      run_sched(n);
      for (int i = 0; i < n; i++) begin
         n_assert++;
         if ({cap_tx[i], cap_busy[i], cap_fin[i]} !== {exp_tx[i], exp_busy[i], exp_fin[i]}) begin
            n_fail++;
            $display("FAIL b2b cycle %0d: tx/busy/fin got %b%b%b expected %b%b%b", i,
                     cap_tx[i], cap_busy[i], cap_fin[i], exp_tx[i], exp_busy[i], exp_fin[i]);
         end
      end
      n_assert++;
      if ({cap_busy[FL + 1], cap_tx[FL + 1], cap_busy[FL + 2], cap_tx[FL + 2]} !== 4'b0110) begin
         n_fail++;
         $display("FAIL b2b_gap: busy/tx at gap and next got %b%b %b%b expected 01 10",
                  cap_busy[FL + 1], cap_tx[FL + 1], cap_busy[FL + 2], cap_tx[FL + 2]);
      end
   endtask

   task automatic test_random();
      int n = 3 * FL + 60;
      for (int rep = 0; rep < 4; rep++) begin
         clear_sched();
         for (int i = 0; i < n - FL - 3; i++) begin
            sch_start[i] = ($urandom_range(0, 24) == 0);
            sch_data[i]  = 8'($urandom);
         end
         sch_start[0] = 1'b1;
         build_model(n);
         run_sched(n);
         for (int i = 0; i < n; i++) begin
            n_assert++;
            if ({cap_tx[i], cap_busy[i], cap_fin[i]} !== {exp_tx[i], exp_busy[i], exp_fin[i]}) begin
               n_fail++;
               $display("FAIL random%0d cycle %0d: tx/busy/fin got %b%b%b expected %b%b%b", rep, i,
                        cap_tx[i], cap_busy[i], cap_fin[i], exp_tx[i], exp_busy[i], exp_fin[i]);
            end
         end
      end
   endtask

   task automatic test_midframe_reset();
      int n = FL + 10;
      clear_sched();
      sch_start[0] = 1'b1;
      sch_data[0]  = 8'h81;
      run_sched(35);
      @(negedge clock);
      n_assert++;
      if (tx !== frame_level(8'h81, 34 / CPB)) begin
         n_fail++;
         $display("FAIL midreset_pre: tx got %b expected %b", tx, frame_level(8'h81, 34 / CPB));
      end
      reset = 1'b0;
      #1;
      n_assert++;
      if ({tx, txbusy, txfinish} !== 3'b100) begin
         n_fail++;
         $display("FAIL midreset_async: tx/busy/fin got %b%b%b expected 100", tx, txbusy, txfinish);
      end
      for (int i = 0; i < 2; i++) begin
         @(negedge clock);
         n_assert++;
         if ({tx, txbusy, txfinish} !== 3'b100) begin
            n_fail++;
            $display("FAIL midreset_hold %0d: tx/busy/fin got %b%b%b expected 100", i, tx, txbusy, txfinish);
         end
      end
      reset = 1'b1;
      clear_sched();
      sch_start[5] = 1'b1;
      sch_data[5]  = 8'h81;
      build_model(n + 5);
      run_sched(n + 5);
      for (int i = 0; i < n + 5; i++) begin
         n_assert++;
         if ({cap_tx[i], cap_busy[i], cap_fin[i]} !== {exp_tx[i], exp_busy[i], exp_fin[i]}) begin
            n_fail++;
            $display("FAIL midreset_after cycle %0d: tx/busy/fin got %b%b%b expected %b%b%b", i,
                     cap_tx[i], cap_busy[i], cap_fin[i], exp_tx[i], exp_busy[i], exp_fin[i]);
         end
      end
   endtask

   // decode the captured line like a receiver: mid-bit sampling after each falling edge
   task automatic test_loopback();
      logic [7:0] sent [3];
      logic [7:0] got [$];
      int n = 3 * (FL + 1) + 20;
      int fin_cnt = 0;
      int i = 1;
      sent[0] = 8'h55;
      sent[1] = 8'hAA;
      sent[2] = 8'h01;
      clear_sched();
      for (int f = 0; f < 3; f++) begin
         sch_start[f * (FL + 4)] = 1'b1;
         sch_data[f * (FL + 4)]  = sent[f];
      end
      run_sched(n);
      for (int j = 0; j < n; j++) if (cap_fin[j] === 1'b1) fin_cnt++;
      while (i < n) begin
         if (cap_tx[i - 1] === 1'b1 && cap_tx[i] === 1'b0) begin
            int m = i + CPB / 2;
            int stop_at = m + (FRAME_BITS - 1) * CPB;
            logic [7:0] b;
            if (stop_at >= n) break;
            for (int k = 0; k < 8; k++) b[k] = cap_tx[m + (k + 1) * CPB];
            n_assert++;
            if ({cap_tx[m], cap_tx[stop_at]} !== 2'b01) begin
               n_fail++;
               $display("FAIL loopback_framing at %0d: start/stop got %b%b expected 01", i, cap_tx[m], cap_tx[stop_at]);
            end
            got.push_back(b);
            i = stop_at;
         end
         i++;
      end
      n_assert++;
      if (got.size() != 3 || fin_cnt != 3) begin
         n_fail++;
         $display("FAIL loopback_count: frames %0d finishes %0d expected 3 and 3", got.size(), fin_cnt);
      end
      for (int f = 0; f < 3 && f < got.size(); f++) begin
         n_assert++;
         if (got[f] !== sent[f]) begin
            n_fail++;
            $display("FAIL loopback_byte%0d: got %h expected %h", f, got[f], sent[f]);
         end
      end
   endtask

`ifdef SERIAL_TRANSMIT_PARITY_EN
   task automatic test_parity();
      int n = 2 * FL + 10;
      int len = 0;
      clear_sched();
      sch_start[0]      = 1'b1;
      sch_data[0]       = 8'h07;
      sch_start[FL + 1] = 1'b1;
      sch_data[FL + 1]  = 8'h03;
      build_model(n);
      run_sched(n);
      for (int i = 0; i < n; i++) begin
         n_assert++;
         if ({cap_tx[i], cap_busy[i], cap_fin[i]} !== {exp_tx[i], exp_busy[i], exp_fin[i]}) begin
            n_fail++;
            $display("FAIL parity cycle %0d: tx/busy/fin got %b%b%b expected %b%b%b", i,
                     cap_tx[i], cap_busy[i], cap_fin[i], exp_tx[i], exp_busy[i], exp_fin[i]);
         end
      end
      n_assert++;
      if ({cap_tx[1 + 9 * CPB + CPB / 2], cap_tx[FL + 2 + 9 * CPB + CPB / 2]} !== 2'b10) begin
         n_fail++;
         $display("FAIL parity_bits: got %b%b expected 10",
                  cap_tx[1 + 9 * CPB + CPB / 2], cap_tx[FL + 2 + 9 * CPB + CPB / 2]);
      end
      for (int i = 1; i <= FL + 1; i++) if (cap_busy[i] === 1'b1) len++;
      n_assert++;
      if (len != 11 * CPB) begin
         n_fail++;
         $display("FAIL parity_frame_len: got %0d expected %0d", len, 11 * CPB);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_single_byte();
      test_ignored_request();
      test_back_to_back();
      test_midframe_reset();
      test_loopback();
`ifdef SERIAL_TRANSMIT_PARITY_EN
      test_parity();
`endif
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/serial_transmit.md
Name: serial_transmit

Overview:
- Asynchronous-serial (UART-style) transmitter; the sending end of the link that `Receive` terminates.
- Accepts one parallel byte per handshake and serialises it as: start bit (0), 8 data bits LSB-first, stop bit (1).
- Each bit is held for a fixed number of clock cycles set by a parameter.
- Sits beside `Receive` in the HW3 design; the two can be looped back for self-test.

Parameters:
- CLKS_PER_BIT, 10, clock cycles per serial bit (>=2); must match the `Receive` instance parameter.
- DATA_BITS, 8, payload width; fixed at 8 for this block, kept as a parameter for the package constant.

Ports:
- clock  in  1  system clock, rising-edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- txdata  in  8  byte to send; sampled only on an accepted start.
- txstart  in  1  request; accepted on a rising clock edge when txbusy=0.
- tx  out  1  serial line; idles high; registered output.
- txbusy  out  1  high from the cycle after acceptance until the frame ends.
- txfinish  out  1  one-cycle pulse, asserted in the last cycle of the stop bit.

Behaviour:
- Reset (reset=0, async): tx=1, txbusy=0, txfinish=0, state=IDLE, bit counter=0, cycle counter=0, shift register=0.
- FSM states: IDLE, START, DATA, STOP (plus PARITY when the optional feature is enabled).
- IDLE:
  - tx=1.
  - On a clock edge with txstart=1: latch txdata into the shift register, clear counters, go to START.
  - txbusy=1 and tx=0 from the next cycle (1-cycle latency from acceptance to start-bit edge).
- START: tx=0 for exactly CLKS_PER_BIT cycles, then DATA.
- DATA:
  - tx = shift[0]; each bit is held CLKS_PER_BIT cycles.
  - Shift right on each bit boundary.
  - After bit index 7 completes, go to STOP.
- STOP:
  - tx=1 for CLKS_PER_BIT cycles.
  - txfinish=1 during the final cycle only.
  - Then IDLE with txbusy=0.
- Frame length: exactly 10*CLKS_PER_BIT cycles from the first tx=0 cycle to the first IDLE cycle.
- Cycle counter: counts 0..CLKS_PER_BIT-1 and wraps at each bit boundary; width clog2(CLKS_PER_BIT).
- txstart while txbusy=1: ignored, no queuing. txdata changes during a frame have no effect.
- txstart in the IDLE cycle immediately after txfinish: accepted, giving back-to-back frames with no extra idle bit.
- txstart held high continuously: one frame per 10*CLKS_PER_BIT+1 cycles.
- Reset asserted mid-frame:
  - tx returns to 1 immediately (asynchronously); the frame is aborted; no txfinish pulse.
  - After release, the block waits in IDLE.
- No glitches on tx: it is driven only from a flop.

Optional Feature:
- Macro: SERIAL_TRANSMIT_PARITY_EN.
- Defined:
  - PARITY state is inserted between DATA and STOP.
  - tx = even parity (XOR of the 8 latched data bits) for CLKS_PER_BIT cycles.
  - Frame is 11*CLKS_PER_BIT cycles; txfinish timing is otherwise unchanged.
- Undefined: no PARITY state; 10-bit frame as above.

Decomposition:
- Shared package serial_pkg:
  - state enum (IDLE, START, DATA, PARITY, STOP);
  - constants DATA_BITS=8, START_LEVEL=0, STOP_LEVEL=1, IDLE_LEVEL=1.
  - `Receive` reuses the same package.
- One sub-module, bit_timer:
  - parameterised CLKS_PER_BIT down-counter;
  - inputs: clear and enable; output: a bit_done pulse on the last cycle of each bit.
  - Reused by the receiver.

Test Plan (CLKS_PER_BIT=10, clock period 10):
- Reset: hold reset=0 for 3 cycles with txstart=1 -> tx=1, txbusy=0, txfinish=0 throughout; no frame starts until reset=1.
- Single byte: txdata=8'hA5, one-cycle txstart pulse ->
  - tx bit sequence 0,1,0,1,0,0,1,0,1,1, each held exactly 10 cycles;
  - txbusy high for 100 cycles;
  - txfinish high in cycle 100 only.
- Ignored request: send 8'h3C; at cycle 40 pulse txstart with txdata=8'hFF -> frame still carries 8'h3C; no second frame follows.
- Back-to-back: txstart held high with txdata=8'h00 then 8'hFF -> two frames separated by exactly one IDLE cycle; stop bit of the first frame intact.
- Mid-frame reset: start 8'h81; drive reset=0 at cycle 35 for 2 cycles -> tx=1 within the same time step; no txfinish; next txstart sends a clean full frame.
- Loopback (with SERIAL_TRANSMIT_PARITY_EN undefined): tx wired to a `Receive#(10)` rx, bytes 8'h55, 8'hAA, 8'h01 -> received data matches each byte; rxfinish occurs once per frame.
- Parity variant (SERIAL_TRANSMIT_PARITY_EN defined): 8'h07 -> parity bit 1; 8'h03 -> parity bit 0; frame lengths 110 cycles.
